// File: rtl/ps2_keymatrix_gen.sv
// rtl/ps2_keymatrix_gen.sv - PS/2 set-2 scancode to keyboard matrix translator
// Run-time loadable scancode map, merged active-low column bus, reset-combo detect.
module ps2_keymatrix_gen #(
    parameter int         ROWS   = 8,
    parameter int         COLS   = 8,
    parameter int         RW     = 3,
    parameter int         CW     = 3,
    parameter logic [6:0] RST_K0 = 7'h17,
    parameter logic [6:0] RST_K1 = 7'h3A,
    parameter logic [6:0] RST_K2 = 7'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        scancode,
    input  logic              receiveflag,
    input  logic [ROWS-1:0]   row,
    input  logic [COLS-1:0]   realkeys,
    input  logic              map_we,
    input  logic [8:0]        map_addr,
    input  logic [RW+CW:0]    map_wdata,
    output logic [COLS-1:0]   kbus,
    output logic              keyreset,
    output logic [7:0]        keycount
);

    localparam int EW = 1 + RW + CW;
    localparam int NK = ROWS * COLS;
    localparam int IW = (NK > 1) ? $clog2(NK) : 1;

    // Flat cell index of a packed {row,col} combo key, or -1 when outside the matrix.
    function automatic int cell_idx(input logic [6:0] k);
        int r;
        int c;
        r = (int'(k) >> CW) & ((1 << RW) - 1);
        c = int'(k) & ((1 << CW) - 1);
        if (r < ROWS && c < COLS) return r * COLS + c;
        return -1;
    endfunction

    localparam int K0I = cell_idx(RST_K0);
    localparam int K1I = cell_idx(RST_K1);
    localparam int K2I = cell_idx(RST_K2);
    localparam bit K0V = (K0I >= 0);
    localparam bit K1V = (K1I >= 0);
    localparam bit K2V = (K2I >= 0);
    localparam int K0S = K0V ? K0I : 0;
    localparam int K1S = K1V ? K1I : 0;
    localparam int K2S = K2V ? K2I : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_REL,
        S_EXTREL,
        S_SKIP
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      skip_q, skip_d;
    logic            pend_q, pend_d;
    logic            press_q, press_d;
    logic [EW-1:0]   map_rdata_q, map_rdata_d;
    logic [NK-1:0]   key_q, key_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [COLS-1:0] kbus_q, kbus_d;
    logic            keyreset_q, keyreset_d;

    logic [EW-1:0]   map_mem [512];
    logic            lk_ext;
    logic [8:0]      lk_addr;
    logic            clr_all;
    logic            ent_valid;
    logic [RW-1:0]   ent_row;
    logic [CW-1:0]   ent_col;
    logic            ent_in_range;
    logic [IW-1:0]   ent_idx;
    logic [COLS-1:0] hit;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        pend_d  = 1'b0;
        press_d = 1'b0;
        lk_ext  = 1'b0;
        clr_all = 1'b0;
        if (receiveflag) begin
            case (state_q)
                S_IDLE: begin
                    if (scancode == 8'hE0)      state_d = S_EXT;
                    else if (scancode == 8'hF0) state_d = S_REL;
                    else if (scancode == 8'hE1) begin
                        state_d = S_SKIP;
                        skip_d  = 3'd7;
                    end else if (scancode == 8'hAA || scancode == 8'hFC) begin
                        clr_all = 1'b1;
                    end else begin
                        pend_d  = 1'b1;
                        press_d = 1'b1;
                    end
                end
                S_EXT: begin
                    if (scancode == 8'hF0)      state_d = S_EXTREL;
                    else if (scancode == 8'hE0) state_d = S_EXT;
                    else if (scancode == 8'h12) state_d = S_IDLE;
                    else begin
                        pend_d  = 1'b1;
                        press_d = 1'b1;
                        lk_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_REL: begin
                    if (scancode == 8'hE0)      state_d = S_EXT;
                    else if (scancode == 8'hF0) state_d = S_REL;
                    else begin
                        pend_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_EXTREL: begin
                    if (scancode == 8'hE0)      state_d = S_EXT;
                    else if (scancode == 8'hF0) state_d = S_REL;
                    else if (scancode == 8'h12) state_d = S_IDLE;
                    else begin
                        pend_d  = 1'b1;
                        lk_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_SKIP: begin
                    // Pause bytes include F0, so they must not abort the skip.
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign lk_addr     = {lk_ext, scancode};
    assign map_rdata_d = map_mem[lk_addr];

    always_ff @(posedge clk) begin
        if (map_we) map_mem[map_addr] <= map_wdata;
        map_rdata_q <= map_rdata_d;
    end

    assign ent_valid    = map_rdata_q[EW-1];
    assign ent_row      = map_rdata_q[CW +: RW];
    assign ent_col      = map_rdata_q[CW-1:0];
    assign ent_in_range = ({1'b0, ent_row} < (RW+1)'(ROWS)) && ({1'b0, ent_col} < (CW+1)'(COLS));
    assign ent_idx      = IW'(ent_row) * IW'(COLS) + IW'(ent_col);

    always_comb begin
        key_d = key_q;
        cnt_d = cnt_q;
        if (pend_q && ent_valid && ent_in_range) begin
            if (press_q && !key_q[ent_idx]) begin
                key_d[ent_idx] = 1'b1;
                cnt_d          = cnt_q + 9'd1;
            end else if (!press_q && key_q[ent_idx]) begin
                key_d[ent_idx] = 1'b0;
                cnt_d          = cnt_q - 9'd1;
            end
        end
        // A clear-all beats a lookup update landing on the same edge.
        if (clr_all) begin
            key_d = '0;
            cnt_d = '0;
        end
    end

    always_comb begin
        hit = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                hit[c] = hit[c] | (~row[r] & key_q[r*COLS+c]);
            end
        end
        kbus_d     = ~hit & realkeys;
        keyreset_d = (K0V & key_q[K0S]) & (K1V & key_q[K1S]) & (K2V & key_q[K2S]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            skip_q     <= '0;
            pend_q     <= 1'b0;
            press_q    <= 1'b0;
            key_q      <= '0;
            cnt_q      <= '0;
            kbus_q     <= '1;
            keyreset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            pend_q     <= pend_d;
            press_q    <= press_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            kbus_q     <= kbus_d;
            keyreset_q <= keyreset_d;
        end
    end

    assign kbus     = kbus_q;
    assign keyreset = keyreset_q;
    assign keycount = cnt_q[8] ? 8'hFF : cnt_q[7:0];

endmodule

// File: tb/tb_ps2_keymatrix_gen.sv
// tb/tb_ps2_keymatrix_gen.sv - directed self-checking bench for ps2_keymatrix_gen
module tb_ps2_keymatrix_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] scancode;
    logic       receiveflag;
    logic [7:0] row;
    logic [7:0] realkeys;
    logic       map_we;
    logic [8:0] map_addr;
    logic [6:0] map_wdata;
    logic [7:0] kbus;
    logic       keyreset;
    logic [7:0] keycount;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ps2_keymatrix_gen dut (
        .clk         (clk),
        .reset       (reset),
        .scancode    (scancode),
        .receiveflag (receiveflag),
        .row         (row),
        .realkeys    (realkeys),
        .map_we      (map_we),
        .map_addr    (map_addr),
        .map_wdata   (map_wdata),
        .kbus        (kbus),
        .keyreset    (keyreset),
        .keycount    (keycount)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scancode    = b;
        receiveflag = 1'b1;
        @(negedge clk);
        receiveflag = 1'b0;
    endtask

    task automatic settle;
        repeat (3) @(negedge clk);
    endtask

    task automatic view(input logic [7:0] r);
        row = r;
        repeat (2) @(negedge clk);
    endtask

    task automatic map_wr(input logic [8:0] a, input logic v, input logic [2:0] r, input logic [2:0] c);
        @(negedge clk);
        map_we    = 1'b1;
        map_addr  = a;
        map_wdata = {v, r, c};
        @(negedge clk);
        map_we    = 1'b0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        scancode    = 8'h00;
        receiveflag = 1'b0;
        row         = 8'hFF;
        realkeys    = 8'hFF;
        map_we      = 1'b0;
        map_addr    = '0;
        map_wdata   = '0;

        map_wr(9'h01C, 1'b1, 3'd1, 3'd2);
        map_wr(9'h175, 1'b1, 3'd5, 3'd3);
        map_wr(9'h075, 1'b1, 3'd3, 3'd3);
        map_wr(9'h014, 1'b1, 3'd4, 3'd4);
        map_wr(9'h077, 1'b1, 3'd6, 3'd6);
        map_wr(9'h023, 1'b1, 3'd2, 3'd0);
        map_wr(9'h01B, 1'b1, 3'd2, 3'd7);
        map_wr(9'h02B, 1'b1, 3'd7, 3'd2);
        map_wr(9'h03B, 1'b1, 3'd0, 3'd0);
        map_wr(9'h04B, 1'b0, 3'd2, 3'd2);

        repeat (2) @(negedge clk);
        expect_eq("rst_kbus", kbus, 8'hFF);
        expect_eq("rst_keycount", keycount, 8'h00);
        expect_eq("rst_keyreset", keyreset, 1'b0);
        reset = 1'b0;

        // Base press with exact latency, then release
        view(8'hFD);
        send(8'h1C);
        @(negedge clk);
        expect_eq("base_kbus_n2", kbus, 8'hFF);
        @(negedge clk);
        expect_eq("base_kbus_n3", kbus, 8'hFB);
        expect_eq("base_count", keycount, 8'd1);
        send(8'hF0); send(8'h1C); settle;
        expect_eq("rel_kbus", kbus, 8'hFF);
        expect_eq("rel_count", keycount, 8'd0);

        // Extended vs base mapping of 75
        send(8'hE0); send(8'h75); settle;
        view(8'hDF); expect_eq("ext_r5", kbus, 8'hF7);
        view(8'hF7); expect_eq("ext_r3", kbus, 8'hFF);
        expect_eq("ext_count", keycount, 8'd1);
        send(8'hE0); send(8'hF0); send(8'h75); settle;
        expect_eq("extrel_count", keycount, 8'd0);
        view(8'hDF); expect_eq("extrel_r5", kbus, 8'hFF);
        send(8'h75); settle;
        view(8'hF7); expect_eq("base75_r3", kbus, 8'hF7);
        expect_eq("base75_count", keycount, 8'd1);
        send(8'hF0); send(8'h75); settle;
        expect_eq("base75_rel", keycount, 8'd0);

        // F0 then E0 aborts the release and becomes an extended press
        send(8'hF0); send(8'hE0); send(8'h75); settle;
        view(8'hDF); expect_eq("abort_r5", kbus, 8'hF7);
        expect_eq("abort_count", keycount, 8'd1);
        send(8'hE0); send(8'hF0); send(8'h75); settle;
        expect_eq("abort_rel", keycount, 8'd0);

        // Pause sequence produces no events
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); settle;
        expect_eq("pause_count", keycount, 8'd0);
        view(8'h00); expect_eq("pause_kbus", kbus, 8'hFF);
        send(8'h1C); settle;
        view(8'hFD); expect_eq("post_pause_kbus", kbus, 8'hFB);
        expect_eq("post_pause_count", keycount, 8'd1);

        // AA and FC clear everything
        send(8'h75); send(8'h23); settle;
        expect_eq("three_count", keycount, 8'd3);
        send(8'hAA); settle;
        expect_eq("aa_count", keycount, 8'd0);
        realkeys = 8'hA5;
        view(8'h00); expect_eq("aa_kbus", kbus, 8'hA5);
        realkeys = 8'hFF;
        send(8'h1C); settle;
        expect_eq("fc_pre", keycount, 8'd1);
        send(8'hFC); settle;
        expect_eq("fc_count", keycount, 8'd0);

        // Reset after E0 drops the extension
        send(8'hE0);
        pulse_reset;
        send(8'h75); settle;
        view(8'hF7); expect_eq("rstmid_r3", kbus, 8'hF7);
        view(8'hDF); expect_eq("rstmid_r5", kbus, 8'hFF);
        expect_eq("rstmid_count", keycount, 8'd1);
        send(8'hAA); settle;

        // Reset combo
        send(8'h3B); send(8'h2B); settle;
        expect_eq("combo_two", keyreset, 1'b0);
        expect_eq("combo_count", keycount, 8'd2);
        send(8'h1B);
        @(negedge clk);
        expect_eq("combo_n2", keyreset, 1'b0);
        @(negedge clk);
        expect_eq("combo_n3", keyreset, 1'b1);
        send(8'hF0); send(8'h2B); settle;
        expect_eq("combo_rel", keyreset, 1'b0);
        send(8'hAA); settle;

        // Merge with real keys, double press / double release
        realkeys = 8'h7F;
        send(8'h23); settle;
        send(8'h23); settle;
        view(8'h00); expect_eq("merge_kbus", kbus, 8'h7E);
        expect_eq("dbl_press", keycount, 8'd1);
        send(8'hF0); send(8'h23); send(8'hF0); send(8'h23); settle;
        expect_eq("dbl_rel", keycount, 8'd0);
        expect_eq("merge_rel_kbus", kbus, 8'h7F);
        realkeys = 8'hFF;

        // Entry with valid=0 changes nothing
        send(8'h4B); settle;
        expect_eq("invalid_count", keycount, 8'd0);

        // Clear-all on the same edge as a pending update
        @(negedge clk);
        scancode    = 8'h1C;
        receiveflag = 1'b1;
        @(negedge clk);
        scancode    = 8'hAA;
        @(negedge clk);
        receiveflag = 1'b0;
        settle;
        expect_eq("collide_count", keycount, 8'd0);
        view(8'hFD); expect_eq("collide_kbus", kbus, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
